// File: rtl/uart_rx_unit_pkg.sv
// Shared UART constants, receiver FSM encoding and the baud divisor helper.
// Used by the RX path, the TX path and the debug unit so frame geometry stays consistent.
package uart_rx_unit_pkg;

  localparam int UART_NB_DATA    = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Rounded clk/(baud*oversample), never below 1 so the tick generator always advances.
  function automatic int baud_div(input longint clk_freq, input longint baud, input longint os);
    longint d;
    d = (clk_freq + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : int'(d);
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// Serial line in, received byte plus done/frame-error strobes and busy out.
// master = receiver side, slave = consumer side (debug unit / bench).
interface uart_rx_unit_if #(
  parameter int NB_DATA = 8
);
  logic               i_rx;
  logic [NB_DATA-1:0] o_rx_data;
  logic               o_rx_done;
  logic               o_frame_error;
  logic               o_busy;

  modport master (input i_rx, output o_rx_data, o_rx_done, o_frame_error, o_busy);
  modport slave  (output i_rx, input o_rx_data, o_rx_done, o_frame_error, o_busy);
endinterface

// File: rtl/uart_rx_unit_baud_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks, no backpressure.
// Counter runs 0..DIV-1 and the tick is decoded from the terminal count.
module baud_tick_gen
  import uart_rx_unit_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = w_wrap;

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver, 16x oversampled; byte + done pulse at mid stop bit (~9.5 bit times after start edge).
// No backpressure: strobes are single-cycle and the consumer must take them when they fire.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int NB_DATA    = UART_NB_DATA,
  parameter int SB_TICK    = 16,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic           i_clock,
  input  logic           i_reset,
  uart_rx_unit_if.master rx_if
);

  localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  uart_state_t        r_state, w_state_nxt;
  logic [3:0]         r_s_cnt, w_s_cnt_nxt;
  logic [NW-1:0]      r_n_cnt, w_n_cnt_nxt;
  logic [NB_DATA-1:0] r_shreg, w_shreg_nxt;
  logic [NB_DATA-1:0] r_data, w_data_nxt;
  logic               r_done, w_done_nxt;
  logic               r_ferr, w_ferr_nxt;
  logic               r_sync1, r_rx_s;
  logic               w_tick;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .o_tick (w_tick)
  );

  // Synchronizer resets to 1 so a reset never looks like a start edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_if.i_rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_n_cnt <= w_n_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = ST_START;
          w_s_cnt_nxt = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s_cnt == 4'(OVERSAMPLE / 2 - 1)) begin
            // A high line at mid start bit is treated as a glitch.
            if (!r_rx_s) begin
              w_state_nxt = ST_DATA;
              w_s_cnt_nxt = '0;
              w_n_cnt_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s_cnt == 4'(OVERSAMPLE - 1)) begin
            w_shreg_nxt = {r_rx_s, r_shreg[NB_DATA-1:1]};
            w_s_cnt_nxt = '0;
            if (r_n_cnt == NW'(NB_DATA - 1)) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_n_cnt_nxt = r_n_cnt + NW'(1);
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_s_cnt == 4'(SB_TICK - 1)) begin
            w_state_nxt = ST_IDLE;
            if (r_rx_s) begin
              w_data_nxt = r_shreg;
              w_done_nxt = 1'b1;
            end else begin
              w_ferr_nxt = 1'b1;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rx_if.o_rx_data     = r_data;
  assign rx_if.o_rx_done     = r_done;
  assign rx_if.o_frame_error = r_ferr;
  assign rx_if.o_busy        = (r_state != ST_IDLE);

endmodule
